// File: rtl/ql_carry_pkg.sv
// rtl/ql_carry_pkg.sv - shared opcodes and defaults for the carry-chain accumulator
package ql_carry_pkg;

    localparam int QL_ACC_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        QL_OP_ADD  = 2'b00,
        QL_OP_SUB  = 2'b01,
        QL_OP_LOAD = 2'b10,
        QL_OP_ADDC = 2'b11
    } ql_op_e;

endpackage

// File: rtl/ql_carry_chain.sv
// rtl/ql_carry_chain.sv - P/G generation feeding a WIDTH-cell ripple of XOR/MUX2 cells
module ql_carry_chain
    import ql_carry_pkg::*;
#(
    parameter int WIDTH = QL_ACC_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI0,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             CMSB
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;

    assign p    = A ^ B;
    assign g    = A & B;
    assign c[0] = CI0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        QL_XOR_MUX2_tsmc u_cell (
            .P      (p[i]),
            .G      (g[i]),
            .CI     (c[i]),
            .SUMOUT (SUM[i]),
            .CO     (c[i+1])
        );
    end

    assign CO   = c[WIDTH];
    assign CMSB = c[WIDTH-1];

endmodule

// File: rtl/ql_xor_mux2_tsmc.sv
// rtl/ql_xor_mux2_tsmc.sv - behavioural model of one XOR/MUX2 carry-chain cell
module QL_XOR_MUX2_tsmc (
    input  logic P,
    input  logic G,
    input  logic CI,
    output logic SUMOUT,
    output logic CO
);

    // Propagate steers the mux: pass the incoming carry, otherwise take generate.
    assign SUMOUT = P ^ CI;
    assign CO     = P ? CI : G;

endmodule

// File: rtl/ql_carry_accum_pipe.sv
// rtl/ql_carry_accum_pipe.sv - two-stage valid/ready accumulator around the carry chain
module ql_carry_accum_pipe
    import ql_carry_pkg::*;
#(
    parameter int WIDTH = QL_ACC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    logic             s1_valid_q, s1_valid_d;
    ql_op_e           s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cflag_q, cflag_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_co_q, out_co_d;
    logic             out_ovf_q, out_ovf_d;
    logic             rdy_en_q, rdy_en_d;

    logic             s2_load;
    logic             accept;
    logic             is_load;
    logic [WIDTH-1:0] chain_a, chain_b, chain_sum;
    logic             chain_ci0, chain_co, chain_cmsb;
    logic             res_co, res_ovf;

    // rdy_en_q keeps in_ready low until the first edge after reset releases.
    always_comb begin
        s2_load  = !acc_clr && s1_valid_q && (!out_valid_q || out_ready);
        in_ready = rdy_en_q && !acc_clr && (!s1_valid_q || s2_load);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        is_load   = (s1_op_q == QL_OP_LOAD);
        chain_a   = is_load ? '0 : acc_q;
        chain_b   = (s1_op_q == QL_OP_SUB) ? ~s1_data_q : s1_data_q;
        case (s1_op_q)
            QL_OP_SUB:  chain_ci0 = 1'b1;
            QL_OP_ADDC: chain_ci0 = cflag_q;
            default:    chain_ci0 = 1'b0;
        endcase
        res_co  = is_load ? 1'b0 : chain_co;
        res_ovf = is_load ? 1'b0 : (chain_cmsb ^ chain_co);
    end

    ql_carry_chain #(.WIDTH(WIDTH)) u_chain (
        .A    (chain_a),
        .B    (chain_b),
        .CI0  (chain_ci0),
        .SUM  (chain_sum),
        .CO   (chain_co),
        .CMSB (chain_cmsb)
    );

    always_comb begin
        rdy_en_d    = 1'b1;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_data_d   = s1_data_q;
        acc_d       = acc_q;
        cflag_d     = cflag_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_co_d    = out_co_q;
        out_ovf_d   = out_ovf_q;
        if (acc_clr) begin
            s1_valid_d  = 1'b0;
            acc_d       = '0;
            cflag_d     = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_op_d    = ql_op_e'(in_op);
                s1_data_d  = in_data;
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end
            if (s2_load) begin
                acc_d       = chain_sum;
                cflag_d     = res_co;
                out_valid_d = 1'b1;
                out_sum_d   = chain_sum;
                out_co_d    = res_co;
                out_ovf_d   = res_ovf;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_en_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= QL_OP_ADD;
            s1_data_q   <= '0;
            acc_q       <= '0;
            cflag_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_co_q    <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            acc_q       <= acc_d;
            cflag_q     <= cflag_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_co_q    <= out_co_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_co    = out_co_q;
    assign out_ovf   = out_ovf_q;

endmodule
